// File: rtl/rs232_receiver.sv
// RS-232 receiver: double-synchronised serial input, mid-bit sampling, LSB-first
// assembly, one-cycle data_valid / frame_err strobes and registered FSM state flags.
module rs232_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 idle,
  output logic                 start,
  output logic                 stop
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t                 state_q;
  logic                   rx_meta_q;
  logic                   rx_s_q;
  logic                   armed_q;
  logic [CW-1:0]          clk_cnt_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= ST_IDLE;
      armed_q    <= 1'b1;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      idle       <= 1'b1;
      start      <= 1'b0;
      stop       <= 1'b0;
    end else begin
      rx_meta_q  <= rx_in;
      rx_s_q     <= rx_meta_q;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          clk_cnt_q <= '0;
          // After a framing error the line must be seen high before a new start is accepted.
          if (!armed_q) begin
            if (rx_s_q) armed_q <= 1'b1;
          end else if (!rx_s_q) begin
            state_q <= ST_START;
            idle    <= 1'b0;
            start   <= 1'b1;
          end
        end

        ST_START: begin
          if (clk_cnt_q == CNT_HALF) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            start     <= 1'b0;
            if (!rx_s_q) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_IDLE;
              idle    <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= ST_STOP;
              stop    <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        ST_STOP: begin
          // Leaving mid-stop-bit lets a back-to-back start edge be caught without a gap.
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= ST_IDLE;
            stop      <= 1'b0;
            idle      <= 1'b1;
            if (rx_s_q) begin
              data_out   <= shift_q;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              armed_q   <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          idle    <= 1'b1;
          start   <= 1'b0;
          stop    <= 1'b0;
        end
      endcase
    end
  end

endmodule
